// File: rtl/udma_filter_addrgen.sv
// Address generator for one uDMA filter channel: turns a latched LINEAR/SLIDING/
// CIRCULAR/2D configuration into a valid/ready stream of L2 byte addresses.
module udma_filter_addrgen #(
  parameter int unsigned L2_AWIDTH_NOAL = 15,
  parameter int unsigned TRANS_SIZE     = 15
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cfg_start_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic [1:0]                cfg_mode_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len2_i,
  output logic [L2_AWIDTH_NOAL-1:0] addr_o,
  output logic [1:0]                datasize_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned AW = L2_AWIDTH_NOAL;
  localparam int unsigned TW = TRANS_SIZE;

  localparam logic [1:0] MODE_LINEAR   = 2'd0;
  localparam logic [1:0] MODE_SLIDING  = 2'd1;
  localparam logic [1:0] MODE_CIRCULAR = 2'd2;
  localparam logic [1:0] MODE_2D       = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    datasize_q, datasize_d;
  logic [TW-1:0] len0_q, len0_d;
  logic [TW-1:0] len1_q, len1_d;
  logic [TW-1:0] len2_q, len2_d;
  logic [AW-1:0] size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [TW-1:0] i_q, i_d;
  logic [TW-1:0] j_q, j_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [TW-1:0] cfg_len1_eff;
  logic          cfg_zero;
  logic [AW-1:0] cfg_size;
  logic [AW-1:0] row_step;
  logic [TW-1:0] len0_m1;
  logic [TW-1:0] len1_m1;
  logic [TW-1:0] i_inc;
  logic [TW-1:0] j_inc;
  logic [AW-1:0] next_row;

  // Configuration decode, and per-row increment of the latched operation
  always_comb begin
    cfg_len1_eff = (cfg_mode_i == MODE_LINEAR) ? TW'(1) : cfg_len1_i;
    cfg_zero     = (cfg_len0_i == '0) || (cfg_len1_eff == '0);
    case (cfg_datasize_i)
      2'd0:    cfg_size = AW'(1);
      2'd1:    cfg_size = AW'(2);
      default: cfg_size = AW'(4);
    endcase
    case (mode_q)
      MODE_SLIDING:  row_step = size_q;
      MODE_CIRCULAR: row_step = '0;
      MODE_2D:       row_step = AW'(len2_q);
      default:       row_step = '0;
    endcase
    len0_m1  = len0_q - TW'(1);
    len1_m1  = len1_q - TW'(1);
    i_inc    = i_q + TW'(1);
    j_inc    = j_q + TW'(1);
    next_row = row_base_q + row_step;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    datasize_d = datasize_q;
    len0_d     = len0_q;
    len1_d     = len1_q;
    len2_d     = len2_q;
    size_d     = size_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    i_d        = i_q;
    j_d        = j_q;
    valid_d    = valid_q;
    last_d     = last_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) begin
          mode_d     = cfg_mode_i;
          datasize_d = cfg_datasize_i;
          len0_d     = cfg_len0_i;
          len1_d     = cfg_len1_eff;
          len2_d     = cfg_len2_i;
          size_d     = cfg_size;
          addr_d     = cfg_start_addr_i;
          row_base_d = cfg_start_addr_i;
          i_d        = '0;
          j_d        = '0;
          if (cfg_zero) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            state_d = ST_RUN;
            valid_d = 1'b1;
            last_d  = (cfg_len0_i == TW'(1)) && (cfg_len1_eff == TW'(1));
          end
        end
      end
      ST_RUN: begin
        if (valid_q && ready_i) begin
          if (last_q) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else if (i_q == len0_m1) begin
            // Row finished: move the row base and restart the inner index
            i_d        = '0;
            j_d        = j_inc;
            row_base_d = next_row;
            addr_d     = next_row;
            last_d     = (len0_m1 == '0) && (j_inc == len1_m1);
          end else begin
            i_d    = i_inc;
            addr_d = addr_q + size_q;
            last_d = (i_inc == len0_m1) && (j_q == len1_m1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mode_q     <= '0;
      datasize_q <= '0;
      len0_q     <= '0;
      len1_q     <= '0;
      len2_q     <= '0;
      size_q     <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      datasize_q <= datasize_d;
      len0_q     <= len0_d;
      len1_q     <= len1_d;
      len2_q     <= len2_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      i_q        <= i_d;
      j_q        <= j_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign addr_o     = addr_q;
  assign datasize_o = datasize_q;
  assign valid_o    = valid_q;
  assign last_o     = last_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_udma_filter_addrgen.sv
// Self-checking bench for udma_filter_addrgen: directed scenarios plus randomized
// runs compared against a nested-loop address model.
module tb_udma_filter_addrgen;

  localparam int AW = 15;
  localparam int TW = 15;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          cfg_start_i;
  logic [AW-1:0] cfg_start_addr_i;
  logic [1:0]    cfg_datasize_i;
  logic [1:0]    cfg_mode_i;
  logic [TW-1:0] cfg_len0_i;
  logic [TW-1:0] cfg_len1_i;
  logic [TW-1:0] cfg_len2_i;
  logic [AW-1:0] addr_o;
  logic [1:0]    datasize_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_q[$];

  udma_filter_addrgen #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TW)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .cfg_start_i      (cfg_start_i),
    .cfg_start_addr_i (cfg_start_addr_i),
    .cfg_datasize_i   (cfg_datasize_i),
    .cfg_mode_i       (cfg_mode_i),
    .cfg_len0_i       (cfg_len0_i),
    .cfg_len1_i       (cfg_len1_i),
    .cfg_len2_i       (cfg_len2_i),
    .addr_o           (addr_o),
    .datasize_o       (datasize_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .last_o           (last_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: full address list of an operation from the mode formulas
  function automatic void build_exp(input int mode, input int ds, input int start,
                                    input int l0, input int l1, input int l2);
    int s, outer, off;
    exp_q.delete();
    s = (ds == 0) ? 1 : (ds == 1) ? 2 : 4;
    outer = (mode == 0) ? 1 : l1;
    for (int j = 0; j < outer; j++) begin
      for (int i = 0; i < l0; i++) begin
        case (mode)
          1:       off = (j + i) * s;
          3:       off = j * l2 + i * s;
          default: off = i * s;
        endcase
        exp_q.push_back((start + off) & 32'h7FFF);
      end
    end
  endfunction

  // Runs one operation; rdy_mode 0 = always ready, 1 = 1,0 toggle, 2 = random.
  // restart_at >= 0 pulses a conflicting start when that beat index is presented.
  task automatic run_op(input string name, input int mode, input int ds, input int start,
                        input int l0, input int l1, input int l2,
                        input int rdy_mode, input int restart_at);
    int n, idx, cyc, bound;
    bit pv, pr, pl, injected;
    logic [AW-1:0] pa;
    build_exp(mode, ds, start, l0, l1, l2);
    n = exp_q.size();
    bound = 8 * n + 20;
    cfg_mode_i       = 2'(mode);
    cfg_datasize_i   = 2'(ds);
    cfg_start_addr_i = AW'(start);
    cfg_len0_i       = TW'(l0);
    cfg_len1_i       = TW'(l1);
    cfg_len2_i       = TW'(l2);
    cfg_start_i      = 1'b1;
    ready_i          = 1'b0;
    @(posedge clk_i); #1;
    cfg_start_i = 1'b0;
    tests_run++;
    if (busy_o !== 1'b1 || datasize_o !== 2'(ds)) begin
      tests_failed++;
      $display("FAIL %s start: busy=%b ds=%0d, want busy=1 ds=%0d", name, busy_o, datasize_o, ds);
    end
    if (n == 0) begin
      tests_run++;
      if (done_o !== 1'b1 || valid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s zero_len: done=%b valid=%b, want done=1 valid=0", name, done_o, valid_o);
      end
      @(posedge clk_i); #1;
      tests_run++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s zero_len_end: done=%b busy=%b valid=%b, want 0 0 0", name, done_o, busy_o, valid_o);
      end
      return;
    end
    idx = 0; cyc = 0; pv = 0; pr = 0; pl = 0; pa = '0; injected = 0;
    while (idx < n && cyc < bound) begin
      if (pv && !pr) begin
        tests_run++;
        if (valid_o !== 1'b1 || addr_o !== pa || last_o !== pl) begin
          tests_failed++;
          $display("FAIL %s hold: valid=%b addr=%h last=%b, want 1 %h %b", name, valid_o, addr_o, last_o, pa, pl);
        end
      end
      tests_run++;
      if (valid_o !== 1'b1 || addr_o !== AW'(exp_q[idx]) || last_o !== (idx == n - 1)) begin
        tests_failed++;
        $display("FAIL %s beat%0d: valid=%b addr=%h last=%b, want 1 %h %b", name, idx, valid_o, addr_o, last_o, AW'(exp_q[idx]), (idx == n - 1));
      end
      case (rdy_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = (cyc % 2 == 0);
        default: ready_i = ($urandom_range(0, 3) != 0);
      endcase
      if (restart_at == idx && !injected) begin
        injected         = 1;
        cfg_start_i      = 1'b1;
        cfg_mode_i       = 2'd0;
        cfg_datasize_i   = 2'd0;
        cfg_start_addr_i = AW'(16'h1234);
        cfg_len0_i       = TW'(9);
      end else begin
        cfg_start_i = 1'b0;
      end
      pv = valid_o; pr = ready_i; pa = addr_o; pl = last_o;
      if (valid_o && ready_i) idx++;
      @(posedge clk_i); #1;
      cyc++;
    end
    ready_i = 1'b0;
    cfg_start_i = 1'b0;
    if (idx < n) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s timeout: beats=%0d, want %0d", name, idx, n);
      return;
    end
    tests_run++;
    if (valid_o !== 1'b0 || done_o !== 1'b1 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s done: valid=%b done=%b busy=%b, want 0 1 1", name, valid_o, done_o, busy_o);
    end
    @(posedge clk_i); #1;
    tests_run++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s idle: done=%b busy=%b valid=%b, want 0 0 0", name, done_o, busy_o, valid_o);
    end
  endtask

  task automatic test_reset;
    rstn_i = 1'b0; cfg_start_i = 1'b0; ready_i = 1'b0;
    cfg_start_addr_i = '0; cfg_datasize_i = '0; cfg_mode_i = '0;
    cfg_len0_i = '0; cfg_len1_i = '0; cfg_len2_i = '0;
    #1;
    tests_run++;
    if ({addr_o, datasize_o, valid_o, last_o, busy_o, done_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset: addr=%h ds=%0d valid=%b last=%b busy=%b done=%b, want all 0", addr_o, datasize_o, valid_o, last_o, busy_o, done_o);
    end
    repeat (3) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_linear;
    run_op("linear", 0, 2, 'h100, 4, 7, 0, 0, -1);
  endtask

  task automatic test_sliding;
    run_op("sliding", 1, 1, 'h0, 3, 2, 0, 0, -1);
    run_op("sliding_stall", 1, 1, 'h0, 3, 2, 0, 1, -1);
  endtask

  task automatic test_2d_wrap;
    run_op("2d_wrap", 3, 0, 'h7FF0, 2, 3, 'h10, 0, -1);
  endtask

  task automatic test_circular_restart;
    run_op("circ_restart", 2, 2, 'h40, 2, 3, 0, 0, 2);
  endtask

  task automatic test_zero_len;
    run_op("zero_len0", 0, 2, 'h80, 0, 1, 0, 0, -1);
    run_op("zero_len1", 2, 1, 'h80, 4, 0, 0, 0, -1);
  endtask

  task automatic test_reset_midrun;
    int beats = 0;
    cfg_mode_i = 2'd0; cfg_datasize_i = 2'd2; cfg_start_addr_i = AW'(16'h200);
    cfg_len0_i = TW'(8); cfg_len1_i = TW'(1); cfg_len2_i = '0;
    cfg_start_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_start_i = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < 20 && beats < 3; c++) begin
      if (valid_o) beats++;
      @(posedge clk_i); #1;
    end
    rstn_i = 1'b0;
    #1;
    tests_run++;
    if ({addr_o, datasize_o, valid_o, last_o, busy_o, done_o} !== '0) begin
      tests_failed++;
      $display("FAIL midrun_reset: addr=%h ds=%0d valid=%b last=%b busy=%b done=%b, want all 0", addr_o, datasize_o, valid_o, last_o, busy_o, done_o);
    end
    ready_i = 1'b0;
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(posedge clk_i); #1;
    tests_run++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_no_done: done=%b busy=%b, want 0 0", done_o, busy_o);
    end
    run_op("after_reset", 0, 2, 'h200, 8, 1, 0, 0, -1);
  endtask

  task automatic test_random;
    int l0, l1, ra;
    for (int k = 0; k < 40; k++) begin
      l0 = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      l1 = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      ra = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1;
      run_op("random", $urandom_range(0, 3), $urandom_range(0, 3), $urandom & 32'h7FFF,
             l0, l1, $urandom & 32'h7FFF, 2, ra);
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_sliding();
    test_2d_wrap();
    test_circular_restart();
    test_zero_len();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
